pcpi_matmul_host: RTL and testbench
===================================

// Module: pcpi_matmul_host
// PURPOSE
// - PCPI initiator for the fused 3x3 matrix-multiply coprocessor (custom-0 opcode 7'b0001011).
// - Takes a 28-word operand stream (A, B, bias, threshold) and issues one load instruction per word.
// - Then issues START, waits for completion, captures pcpi_rd and issues CLEAR.
// - Used for SoC bring-up and as a CPU-free driver when the core is held off the coprocessor bus.
// PARAMETERS
// - TIMEOUT_CYC   64  max cycles pcpi_valid is held for any single instruction before abort
// - START_MASK     2  cycles after START assertion during which pcpi_ready is ignored
// PORTS
// - clk         in   1   single clock, all state on rising edge
// - resetn      in   1   asynchronous, active-low reset
// - go          in   1   1-cycle pulse: begin a job (ignored unless busy=0)
// - in_valid    in   1   operand word available
// - in_data     in  16   signed operand word, order A[0..8], B[0..8], bias[0..8], threshold
// - in_ready    out  1   word consumed this cycle when in_valid&in_ready
// - pcpi_valid  out  1   instruction request to coprocessor
// - pcpi_insn   out 32   {1'b0, value[15:0], funct3[2:0], addr[4:0], 7'b0001011}
// - pcpi_wr     in   1   coprocessor writes pcpi_rd
// - pcpi_rd     in  32   coprocessor result
// - pcpi_wait   in   1   coprocessor busy
// - pcpi_ready  in   1   coprocessor instruction done
// - busy        out  1   job in progress
// - res_valid   out  1   1-cycle pulse: res_data valid, job complete
// - res_data    out 32   captured pcpi_rd (when pcpi_wr=1 at completion, else 0)
// - err         out  1   sticky timeout flag, cleared by next accepted go
// BEHAVIOUR
// - Reset (async, resetn=0): state IDLE; all outputs 0; word index 0; pcpi_insn 0.
// - States: IDLE -> FETCH -> ISSUE -> GAP -> (FETCH | START) -> WAIT -> CLEAR -> DONE -> IDLE.
// - IDLE: busy=0. go=1 -> FETCH, idx=0, err=0.
// - FETCH: in_ready=1; on in_valid latch word, build insn funct3=000, addr=idx, -> ISSUE.
//   in_ready is combinational from state only (never depends on in_valid).
// - ISSUE: pcpi_valid=1, insn stable; on pcpi_ready=1 -> GAP.
// - GAP: pcpi_valid=0 for exactly 1 cycle; idx<27 -> idx+1, FETCH; idx==27 -> START.
// - START: pcpi_valid=1, funct3=111, addr=0, value=0; enter WAIT same cycle count.
// - WAIT: hold pcpi_valid=1; pcpi_ready ignored for first START_MASK cycles (stale ready);
//   afterwards complete on pcpi_ready=1 & pcpi_wait=0: res_data<=pcpi_wr?pcpi_rd:0 -> CLEAR.
// - CLEAR: one instruction funct3=101, same valid/ready rule as ISSUE; -> DONE.
// - DONE: res_valid=1 for 1 cycle, busy drops next cycle, -> IDLE.
// - Timeout: per-instruction counter cleared on entering ISSUE/START/CLEAR; reaching
//   TIMEOUT_CYC with no completion -> pcpi_valid=0, err=1, res_valid pulse with res_data=0, IDLE.
// - Load instruction count per job exactly 28 (addr 0..27); no addr >27 ever emitted.
// - in_valid during non-FETCH states: ignored, word not consumed.
// - go while busy=1: ignored. go and DONE same cycle: ignored (busy still 1).
// - pcpi_insn changes only while pcpi_valid=0 or on state transition into a new instruction.
// - Mid-job resetn=0: immediate abort, all outputs 0; coprocessor state is not cleaned up.
// TESTING
// - Full job: go, stream 28 words (A=I, B=1..9, bias=0, thr=-70), model responder ->
//   28 loads addr 0..27 with correct insn, START, CLEAR, res_valid once, err=0.
// - Encoding: word 16'h8001 at idx 5 -> pcpi_insn=32'h40008000|(5<<7)|7'h0B.
// - Stalled stream: in_valid low 10 cycles mid-job -> pcpi_valid low, no extra insn, job completes.
// - Stale ready: responder holds pcpi_ready=1 at START -> no completion before START_MASK+1 cycles.
// - Timeout: responder never asserts ready on START -> err=1 after 64 cycles, res_data=0, busy=0.
// - Async reset asserted during WAIT -> outputs 0 same edge-free; new go afterwards runs cleanly.

Source files
------------

// File: rtl/pcpi_matmul_host_if.sv
// PCPI bus between the matmul host (master) and the coprocessor (slave).
interface pcpi_matmul_host_if;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        pcpi_wait;
  logic        pcpi_ready;

  modport master (
    output pcpi_valid, pcpi_insn,
    input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready
  );

  modport slave (
    input  pcpi_valid, pcpi_insn,
    output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready
  );
endinterface

// File: rtl/pcpi_matmul_host.sv
// PCPI initiator for the fused 3x3 matmul coprocessor: streams 28 operand loads,
// then START, waits for the result, and finishes with CLEAR.
module pcpi_matmul_host #(
  parameter int TIMEOUT_CYC = 64,
  parameter int START_MASK  = 2
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                go,
  input  logic                in_valid,
  input  logic signed [15:0]  in_data,
  output logic                in_ready,
  pcpi_matmul_host_if.master  pcpi,
  output logic                busy,
  output logic                res_valid,
  output logic [31:0]         res_data,
  output logic                err
);

  localparam logic [6:0] OPCODE   = 7'b0001011;
  localparam logic [2:0] F3_LOAD  = 3'b000;
  localparam logic [2:0] F3_START = 3'b111;
  localparam logic [2:0] F3_CLEAR = 3'b101;
  localparam logic [4:0] LAST_IDX = 5'd27;
  localparam int         CNT_W    = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, ISSUE, GAP, START, WAIT, CLEAR, DONE
  } state_t;

  state_t           state, state_n;
  logic [4:0]       idx;
  logic [CNT_W-1:0] cnt;
  logic             complete;
  logic             abort;
  logic             timeout;
  logic             mask_over;

  function automatic logic [31:0] encode(input logic [15:0] value,
                                         input logic [2:0]  f3,
                                         input logic [4:0]  addr);
    return {1'b0, value, f3, addr, OPCODE};
  endfunction

  // cnt counts cycles pcpi_valid has been held for the current instruction
  assign timeout   = (cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign mask_over = (cnt >= CNT_W'(START_MASK));
  assign busy      = (state != IDLE);
  assign res_valid = (state == DONE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n         = state;
    in_ready        = 1'b0;
    pcpi.pcpi_valid = 1'b0;
    complete        = 1'b0;
    abort           = 1'b0;
    case (state)
      IDLE: if (go) state_n = FETCH;
      FETCH: begin
        in_ready = 1'b1;
        if (in_valid) state_n = ISSUE;
      end
      ISSUE, CLEAR: begin
        pcpi.pcpi_valid = 1'b1;
        if (pcpi.pcpi_ready) begin
          complete = 1'b1;
          state_n  = (state == ISSUE) ? GAP : DONE;
        end else if (timeout) begin
          abort   = 1'b1;
          state_n = DONE;
        end
      end
      GAP: state_n = (idx == LAST_IDX) ? START : FETCH;
      START: begin
        pcpi.pcpi_valid = 1'b1;
        state_n         = WAIT;
      end
      // a ready still high from the previous instruction is masked out here
      WAIT: begin
        pcpi.pcpi_valid = 1'b1;
        if (mask_over && pcpi.pcpi_ready && !pcpi.pcpi_wait) begin
          complete = 1'b1;
          state_n  = CLEAR;
        end else if (timeout) begin
          abort   = 1'b1;
          state_n = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      idx            <= '0;
      cnt            <= '0;
      pcpi.pcpi_insn <= '0;
      res_data       <= '0;
      err            <= 1'b0;
    end else begin
      if (state == IDLE && go) begin
        idx <= '0;
        err <= 1'b0;
      end
      if (state == FETCH && in_valid) begin
        pcpi.pcpi_insn <= encode(in_data, F3_LOAD, idx);
        cnt            <= '0;
      end else if (state == GAP && idx == LAST_IDX) begin
        pcpi.pcpi_insn <= encode(16'd0, F3_START, 5'd0);
        cnt            <= '0;
      end else if (state == WAIT && complete) begin
        pcpi.pcpi_insn <= encode(16'd0, F3_CLEAR, 5'd0);
        cnt            <= '0;
        res_data       <= pcpi.pcpi_wr ? pcpi.pcpi_rd : 32'd0;
      end else if (pcpi.pcpi_valid) begin
        cnt <= cnt + 1'b1;
      end
      if (state == GAP && idx != LAST_IDX) idx <= idx + 1'b1;
      if (abort) begin
        err      <= 1'b1;
        res_data <= 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_pcpi_matmul_host.sv
// Directed bench for pcpi_matmul_host with a behavioural PCPI responder.
module tb_pcpi_matmul_host;
  logic               clk = 1'b0;
  logic               resetn = 1'b0;
  logic               go = 1'b0;
  logic               in_valid = 1'b0;
  logic signed [15:0] in_data = '0;
  logic               in_ready, busy, res_valid, err;
  logic [31:0]        res_data;

  pcpi_matmul_host_if pcpi();

  pcpi_matmul_host dut (
    .clk(clk), .resetn(resetn), .go(go), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .pcpi(pcpi), .busy(busy), .res_valid(res_valid),
    .res_data(res_data), .err(err)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] INSN_START = 32'h0000700B;
  localparam logic [31:0] INSN_CLEAR = 32'h0000500B;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // responder knobs (written only by the main initial block)
  int          load_lat = 1;
  int          start_lat = 3;
  int          clear_lat = 0;
  bit          start_never = 0;
  bit          start_stale = 0;
  bit          rd_wr = 1;
  logic [31:0] rd_val = 32'h1234_5678;
  logic [31:0] issued[$];

  initial begin : responder
    int          age;
    logic        prev_valid;
    logic [31:0] prev_insn;
    logic [2:0]  f3;
    age = 0; prev_valid = 0; prev_insn = '0;
    pcpi.pcpi_ready = 0; pcpi.pcpi_wait = 0; pcpi.pcpi_wr = 0; pcpi.pcpi_rd = '0;
    forever begin
      @(posedge clk); #1;
      pcpi.pcpi_rd = rd_val;
      if (!pcpi.pcpi_valid) begin
        age = 0;
        pcpi.pcpi_ready = 0; pcpi.pcpi_wait = 0; pcpi.pcpi_wr = 0;
      end else begin
        if (!prev_valid || pcpi.pcpi_insn != prev_insn) begin
          age = 0;
          issued.push_back(pcpi.pcpi_insn);
        end else age++;
        f3 = pcpi.pcpi_insn[14:12];
        if (f3 == 3'b111 && start_stale) begin
          pcpi.pcpi_ready = 1; pcpi.pcpi_wait = 0;
        end else if (f3 == 3'b111 && start_never) begin
          pcpi.pcpi_ready = 0; pcpi.pcpi_wait = 1;
        end else begin
          pcpi.pcpi_ready = (age == ((f3 == 3'b111) ? start_lat :
                                     (f3 == 3'b101) ? clear_lat : load_lat));
          pcpi.pcpi_wait  = (f3 == 3'b111) && !pcpi.pcpi_ready;
        end
        pcpi.pcpi_wr = (f3 == 3'b111) && pcpi.pcpi_ready && rd_wr;
      end
      prev_valid = pcpi.pcpi_valid;
      prev_insn  = pcpi.pcpi_insn;
    end
  end

  int          res_cnt = 0;
  int          start_cyc = 0;
  logic [31:0] last_res = '0;
  logic        last_err = 0;

  always @(negedge clk) begin
    if (res_valid) begin
      res_cnt++;
      last_res = res_data;
      last_err = err;
    end
    if (pcpi.pcpi_valid && pcpi.pcpi_insn == INSN_START) start_cyc++;
  end

  logic [15:0] stream[28];

  typedef struct {
    int          idx;
    logic [15:0] word;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[6];

  task automatic pulse_go();
    @(negedge clk); go = 1;
    @(negedge clk); go = 0;
  endtask

  // stall_at: word index before which in_valid drops for 10 cycles (-1 = none)
  task automatic feed(input int stall_at, output int bad);
    int n;
    bad = 0;
    for (int i = 0; i < 28; i++) begin
      if (i == stall_at) begin
        in_valid = 0;
        for (int s = 0; s < 10; s++) begin
          @(negedge clk);
          go = (s == 0);
          if (s >= 5 && (pcpi.pcpi_valid || !in_ready)) bad++;
        end
        go = 0;
      end
      in_valid = 1;
      in_data  = stream[i];
      n = 0;
      while (!in_ready && n < 500) begin @(negedge clk); n++; end
      if (n >= 500) bad++;
      @(negedge clk);
    end
    in_valid = 0;
  endtask

  task automatic wait_res(output int got);
    int n;
    n = 0;
    got = 0;
    while (n < 300 && !got) begin
      @(negedge clk);
      if (res_valid) got = 1;
      n++;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},       busy, 0);
    chk({tag, "_in_ready"},   in_ready, 0);
    chk({tag, "_pcpi_valid"}, pcpi.pcpi_valid, 0);
    chk({tag, "_pcpi_insn"},  pcpi.pcpi_insn, 0);
    chk({tag, "_res_valid"},  res_valid, 0);
    chk({tag, "_res_data"},   res_data, 0);
    chk({tag, "_err"},        err, 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int base, r0, s0, got, bad, exp_load;
    logic [4:0] a;

    tbl[0] = '{0,  16'h0001, 32'h0000800B};
    tbl[1] = '{5,  16'h8001, 32'h4000828B};
    tbl[2] = '{9,  16'h0001, 32'h0000848B};
    tbl[3] = '{17, 16'h0009, 32'h0004888B};
    tbl[4] = '{26, 16'h7FFF, 32'h3FFF8D0B};
    tbl[5] = '{27, 16'hFFBA, 32'h7FDD0D8B};

    // A = identity, B = 1..9, bias = 0, threshold = -70
    for (int i = 0; i < 28; i++) stream[i] = 16'h0000;
    stream[0] = 16'd1; stream[4] = 16'd1; stream[8] = 16'd1;
    for (int i = 0; i < 9; i++) stream[9 + i] = 16'(i + 1);
    stream[27] = 16'hFFBA;

    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    resetn = 1;
    repeat (2) @(negedge clk);

    // full job
    base = issued.size(); r0 = res_cnt;
    pulse_go();
    chk("job1_busy", busy, 1);
    feed(-1, bad);
    wait_res(got);
    chk("job1_res_seen", got, 1);
    chk("job1_res_data", last_res, 32'h1234_5678);
    chk("job1_err", last_err, 0);
    chk("job1_res_pulses", res_cnt - r0, 1);
    chk("job1_busy_end", busy, 0);
    chk("job1_insn_count", issued.size() - base, 30);
    for (int i = 0; i < 28; i++) begin
      a = 5'(i);
      chk($sformatf("job1_load%0d", i), issued[base + i],
          {1'b0, stream[i], 3'b000, a, 7'h0B});
    end
    chk("job1_start", issued[base + 28], INSN_START);
    chk("job1_clear", issued[base + 29], INSN_CLEAR);

    // table words, stall mid-stream with go while busy, pcpi_wr=0 at completion
    for (int v = 0; v < 6; v++) stream[tbl[v].idx] = tbl[v].word;
    rd_wr = 0;
    base = issued.size(); r0 = res_cnt;
    pulse_go();
    feed(12, bad);
    wait_res(got);
    chk("job2_stall_quiet", bad, 0);
    chk("job2_res_seen", got, 1);
    chk("job2_res_data_nowr", last_res, 0);
    chk("job2_res_pulses", res_cnt - r0, 1);
    chk("job2_insn_count", issued.size() - base, 30);
    for (int v = 0; v < 6; v++)
      chk($sformatf("enc_idx%0d", tbl[v].idx), issued[base + tbl[v].idx], tbl[v].exp);
    exp_load = 0;
    for (int i = 0; i < 28; i++) if (issued[base + i][11:7] == 5'(i)) exp_load++;
    chk("job2_addr_seq", exp_load, 28);
    rd_wr = 1;

    // stale ready held through START
    start_stale = 1;
    s0 = start_cyc;
    pulse_go();
    feed(-1, bad);
    wait_res(got);
    chk("stale_res_seen", got, 1);
    chk("stale_start_cycles", start_cyc - s0, 3);
    chk("stale_res_data", last_res, 32'h1234_5678);
    start_stale = 0;

    // START never acknowledged
    start_never = 1;
    base = issued.size(); s0 = start_cyc;
    pulse_go();
    feed(-1, bad);
    wait_res(got);
    chk("tmo_res_seen", got, 1);
    chk("tmo_err_at_pulse", last_err, 1);
    chk("tmo_res_data", last_res, 0);
    chk("tmo_valid_cycles", start_cyc - s0, 64);
    chk("tmo_busy", busy, 0);
    chk("tmo_err_sticky", err, 1);
    chk("tmo_no_clear", issued.size() - base, 29);

    // async reset while waiting on START
    pulse_go();
    chk("go_clears_err", err, 0);
    feed(-1, bad);
    got = 0;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clk);
      if (pcpi.pcpi_valid && pcpi.pcpi_insn == INSN_START) got = 1;
    end
    chk("rst_reached_wait", got, 1);
    repeat (5) @(negedge clk);
    #2 resetn = 0;
    #1 chk_reset_outputs("midrst");
    @(negedge clk); resetn = 1;
    start_never = 0;
    repeat (2) @(negedge clk);

    // clean job after reset
    base = issued.size(); r0 = res_cnt;
    pulse_go();
    feed(-1, bad);
    wait_res(got);
    chk("post_rst_res_seen", got, 1);
    chk("post_rst_res_data", last_res, 32'h1234_5678);
    chk("post_rst_err", last_err, 0);
    chk("post_rst_pulses", res_cnt - r0, 1);
    chk("post_rst_insn_count", issued.size() - base, 30);
    chk("post_rst_first_load", issued[base], 32'h0000800B);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
